reservation_station: RTL and testbench

//  Holds ALU/branch ops pushed by the issue stage until both operands are valid.

---
 rtl/reservation_station.sv | 201 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds ALU/branch ops until both operands are valid, snoops the ALU/LSB CDBs,
// and dispatches the issue-selected entry to the ALU. Optional macro RS_AGE_SEL_EN adds oldest-first ready selection.
module reservation_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned RS_W    = 4,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned DATA_W  = 32
`ifdef RS_AGE_SEL_EN
  ,
  parameter int unsigned AGE_W   = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [RS_W-1:0]   push_pos,
  input  logic [OP_W-1:0]   push_op,
  input  logic [4:0]        push_rd,
  input  logic [DATA_W-1:0] push_imm,
  input  logic [DATA_W-1:0] push_pc,
  input  logic [ROB_W-1:0]  push_robpos,
  input  logic [DATA_W-1:0] push_vj,
  input  logic [DATA_W-1:0] push_vk,
  input  logic              push_qj,
  input  logic              push_qk,
  output logic              rs_avail,
  output logic [RS_W-1:0]   rs_avail_pos,
  output logic              rs_ready,
  output logic [RS_W-1:0]   rs_ready_pos,
  input  logic              front,
  input  logic [RS_W-1:0]   front_pos,
  input  logic              alu_cdb_valid,
  input  logic [ROB_W-1:0]  alu_cdb_robpos,
  input  logic [DATA_W-1:0] alu_cdb_val,
  input  logic              lsb_cdb_valid,
  input  logic [ROB_W-1:0]  lsb_cdb_robpos,
  input  logic [DATA_W-1:0] lsb_cdb_val,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [4:0]        alu_rd,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc,
  output logic [ROB_W-1:0]  alu_robpos,
  output logic [DATA_W-1:0] alu_vj,
  output logic [DATA_W-1:0] alu_vk
);

  typedef struct packed {
    logic              q;
    logic [DATA_W-1:0] v;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [ROB_W-1:0]  robpos;
    operand_t          j;
    operand_t          k;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] ready_vec;
  entry_t             entries [RS_SIZE];
  entry_t             push_entry;

  // A pending operand holds its ROB tag in the low bits of v; capture a matching broadcast.
  function automatic operand_t snoop(input operand_t o);
    operand_t r;
    r = o;
    if (o.q && alu_cdb_valid && (o.v[ROB_W-1:0] == alu_cdb_robpos)) begin
      r.q = 1'b0;
      r.v = alu_cdb_val;
    end else if (o.q && lsb_cdb_valid && (o.v[ROB_W-1:0] == lsb_cdb_robpos)) begin
      r.q = 1'b0;
      r.v = lsb_cdb_val;
    end
    return r;
  endfunction

  always_comb begin
    push_entry        = '0;
    push_entry.op     = push_op;
    push_entry.rd     = push_rd;
    push_entry.imm    = push_imm;
    push_entry.pc     = push_pc;
    push_entry.robpos = push_robpos;
    push_entry.j      = snoop({push_qj, push_vj});
    push_entry.k      = snoop({push_qk, push_vk});
  end

  // Readiness uses registered state only, so a CDB wakeup shows up one cycle later.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && !entries[i].j.q && !entries[i].k.q;
    end
  end

  always_comb begin
    rs_avail     = 1'b0;
    rs_avail_pos = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        rs_avail     = 1'b1;
        rs_avail_pos = RS_W'(i);
      end
    end
  end

`ifdef RS_AGE_SEL_EN
  logic [AGE_W-1:0] age [RS_SIZE];
  logic [AGE_W-1:0] best_age;

  // Oldest ready entry wins; strict compare keeps ties on the lowest index.
  always_comb begin
    rs_ready     = 1'b0;
    rs_ready_pos = '0;
    best_age     = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && (!rs_ready || (age[i] > best_age))) begin
        rs_ready     = 1'b1;
        rs_ready_pos = RS_W'(i);
        best_age     = age[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (push && (push_pos == RS_W'(i))) begin
          age[i] <= '0;
        end else if (busy[i] && (age[i] != {AGE_W{1'b1}})) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  always_comb begin
    rs_ready     = 1'b0;
    rs_ready_pos = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        rs_ready     = 1'b1;
        rs_ready_pos = RS_W'(i);
      end
    end
  end
`endif

  // Entry storage, snoop, push and dispatch; clear overrides everything but keeps payload bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_rd     <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_robpos <= '0;
      alu_vj     <= '0;
      alu_vk     <= '0;
      for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
    end else if (clear) begin
      busy      <= '0;
      alu_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          entries[i].j <= snoop(entries[i].j);
          entries[i].k <= snoop(entries[i].k);
        end
      end
      if (push) begin
        entries[push_pos] <= push_entry;
        busy[push_pos]    <= 1'b1;
      end
      if (front) begin
        alu_valid       <= 1'b1;
        alu_op          <= entries[front_pos].op;
        alu_rd          <= entries[front_pos].rd;
        alu_imm         <= entries[front_pos].imm;
        alu_pc          <= entries[front_pos].pc;
        alu_robpos      <= entries[front_pos].robpos;
        alu_vj          <= entries[front_pos].j.v;
        alu_vk          <= entries[front_pos].k.v;
        busy[front_pos] <= 1'b0;
      end else begin
        alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station: push/dispatch, CDB wakeup, full, clear, reset.
module tb_reservation_station;

  logic        clk, rst, clear, push, front;
  logic [3:0]  push_pos, push_robpos, front_pos;
  logic [5:0]  push_op;
  logic [4:0]  push_rd;
  logic [31:0] push_imm, push_pc, push_vj, push_vk;
  logic        push_qj, push_qk;
  logic        rs_avail, rs_ready;
  logic [3:0]  rs_avail_pos, rs_ready_pos;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_robpos, lsb_cdb_robpos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_valid;
  logic [5:0]  alu_op;
  logic [4:0]  alu_rd;
  logic [31:0] alu_imm, alu_pc, alu_vj, alu_vk;
  logic [3:0]  alu_robpos;

  int n_tests = 0;
  int n_fail  = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_pos(push_pos),
    .push_op(push_op), .push_rd(push_rd), .push_imm(push_imm), .push_pc(push_pc),
    .push_robpos(push_robpos), .push_vj(push_vj), .push_vk(push_vk),
    .push_qj(push_qj), .push_qk(push_qk),
    .rs_avail(rs_avail), .rs_avail_pos(rs_avail_pos),
    .rs_ready(rs_ready), .rs_ready_pos(rs_ready_pos),
    .front(front), .front_pos(front_pos),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robpos(alu_cdb_robpos), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_robpos(lsb_cdb_robpos), .lsb_cdb_val(lsb_cdb_val),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_rd(alu_rd), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_robpos(alu_robpos), .alu_vj(alu_vj), .alu_vk(alu_vk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; front = 1'b0; clear = 1'b0;
    alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
  endtask

  task automatic set_push(input logic [3:0] pos, input logic [31:0] vj, input logic qj,
                          input logic [31:0] vk, input logic qk, input logic [3:0] rob);
    push = 1'b1; push_pos = pos; push_op = 6'h01; push_rd = 5'd3;
    push_imm = 32'h100 + 32'(pos); push_pc = 32'h1000 + 32'(pos) * 32'd4;
    push_robpos = rob; push_vj = vj; push_qj = qj; push_vk = vk; push_qk = qk;
  endtask

  // Dispatching an unready slot is illegal, so confirm readiness before asserting front.
  task automatic do_front(input logic [3:0] pos);
    chk("front_legal", 32'(rs_ready), 32'd1);
    front = 1'b1; front_pos = pos;
  endtask

  initial begin
    rst = 1'b1; idle();
    push_pos = '0; push_op = '0; push_rd = '0; push_imm = '0; push_pc = '0;
    push_robpos = '0; push_vj = '0; push_vk = '0; push_qj = 1'b0; push_qk = 1'b0;
    front_pos = '0; alu_cdb_robpos = '0; alu_cdb_val = '0; lsb_cdb_robpos = '0; lsb_cdb_val = '0;
    step(); step();
    chk("rst_avail", 32'(rs_avail), 32'd1);
    chk("rst_avail_pos", 32'(rs_avail_pos), 32'd0);
    chk("rst_ready", 32'(rs_ready), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_alu_vj", alu_vj, 32'd0);
    rst = 1'b0;
    step();

    // Ready op pushed then dispatched.
    set_push(4'd0, 32'd5, 1'b0, 32'd7, 1'b0, 4'd1); step(); idle();
    chk("t2_ready", 32'(rs_ready), 32'd1);
    chk("t2_ready_pos", 32'(rs_ready_pos), 32'd0);
    chk("t2_avail_pos", 32'(rs_avail_pos), 32'd1);
    do_front(4'd0); step(); idle();
    chk("t2_alu_valid", 32'(alu_valid), 32'd1);
    chk("t2_alu_vj", alu_vj, 32'd5);
    chk("t2_alu_vk", alu_vk, 32'd7);
    chk("t2_alu_op", 32'(alu_op), 32'h01);
    chk("t2_alu_rd", 32'(alu_rd), 32'd3);
    chk("t2_alu_imm", alu_imm, 32'h100);
    chk("t2_alu_pc", alu_pc, 32'h1000);
    chk("t2_alu_robpos", 32'(alu_robpos), 32'd1);
    chk("t2_freed", 32'(rs_avail_pos), 32'd0);
    chk("t2_not_ready", 32'(rs_ready), 32'd0);
    step();
    chk("t2_valid_pulse", 32'(alu_valid), 32'd0);

    // Pending j operand woken by the ALU CDB.
    set_push(4'd0, 32'd3, 1'b1, 32'd11, 1'b0, 4'd2); step(); idle();
    chk("t3_wait0", 32'(rs_ready), 32'd0);
    step();
    chk("t3_wait1", 32'(rs_ready), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_robpos = 4'd3; alu_cdb_val = 32'h2A;
    #1 chk("t3_ready_regd", 32'(rs_ready), 32'd0);
    step(); idle();
    chk("t3_ready", 32'(rs_ready), 32'd1);
    do_front(4'd0); step(); idle();
    chk("t3_alu_vj", alu_vj, 32'h2A);
    chk("t3_alu_vk", alu_vk, 32'd11);

    // Pending k operand captured from the LSB CDB in the push cycle.
    set_push(4'd0, 32'd1, 1'b0, 32'd6, 1'b1, 4'd4);
    lsb_cdb_valid = 1'b1; lsb_cdb_robpos = 4'd6; lsb_cdb_val = 32'd9;
    step(); idle();
    chk("t4_ready", 32'(rs_ready), 32'd1);
    do_front(4'd0); step(); idle();
    chk("t4_alu_vk", alu_vk, 32'd9);
    chk("t4_alu_vj", alu_vj, 32'd1);

    // Both operands pending; a non-matching tag must not wake, then both CDBs fire together.
    set_push(4'd0, 32'd4, 1'b1, 32'd5, 1'b1, 4'd9); step(); idle();
    alu_cdb_valid = 1'b1; alu_cdb_robpos = 4'd7; alu_cdb_val = 32'hDEAD;
    step(); idle();
    chk("t8_no_wake", 32'(rs_ready), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_robpos = 4'd4; alu_cdb_val = 32'h11;
    lsb_cdb_valid = 1'b1; lsb_cdb_robpos = 4'd5; lsb_cdb_val = 32'h22;
    step(); idle();
    chk("t8_ready", 32'(rs_ready), 32'd1);
    do_front(4'd0); step(); idle();
    chk("t8_alu_vj", alu_vj, 32'h11);
    chk("t8_alu_vk", alu_vk, 32'h22);

    // Fill all 16 slots, then free one.
    for (int i = 0; i < 16; i++) begin
      chk("t5_avail_pos", 32'(rs_avail_pos), 32'(i));
      set_push(4'(i), 32'(i), 1'b0, 32'(100 + i), 1'b0, 4'(i));
      step(); idle();
    end
    chk("t5_full", 32'(rs_avail), 32'd0);
    chk("t5_ready_pos", 32'(rs_ready_pos), 32'd0);
    do_front(4'd5); step(); idle();
    chk("t5_alu_vj", alu_vj, 32'd5);
    chk("t5_alu_vk", alu_vk, 32'd105);
    chk("t5_avail", 32'(rs_avail), 32'd1);
    chk("t5_avail_pos_freed", 32'(rs_avail_pos), 32'd5);

    // Clear drops everything and kills the pending alu_valid.
    clear = 1'b1; step(); idle();
    chk("clr_avail_pos", 32'(rs_avail_pos), 32'd0);
    chk("clr_ready", 32'(rs_ready), 32'd0);
    chk("clr_alu_valid", 32'(alu_valid), 32'd0);

    // Eight busy, then clear together with push and front.
    for (int i = 0; i < 8; i++) begin
      set_push(4'(i), 32'(i), 1'b0, 32'd0, 1'b0, 4'(i));
      step(); idle();
    end
    chk("t6_avail_pos8", 32'(rs_avail_pos), 32'd8);
    clear = 1'b1;
    set_push(4'd8, 32'd77, 1'b0, 32'd0, 1'b0, 4'd8);
    do_front(4'd2);
    step(); idle();
    chk("t6_avail", 32'(rs_avail), 32'd1);
    chk("t6_avail_pos", 32'(rs_avail_pos), 32'd0);
    chk("t6_ready", 32'(rs_ready), 32'd0);
    chk("t6_alu_valid", 32'(alu_valid), 32'd0);
    step();
    chk("t6_no_entry", 32'(rs_ready), 32'd0);
    chk("t6_alu_valid2", 32'(alu_valid), 32'd0);

    // Async reset in the middle of a dispatch cycle.
    set_push(4'd0, 32'd3, 1'b0, 32'd4, 1'b0, 4'd0); step(); idle();
    do_front(4'd0);
    #2 rst = 1'b1;
    #1 front = 1'b0;
    chk("t7_avail_pos", 32'(rs_avail_pos), 32'd0);
    chk("t7_ready", 32'(rs_ready), 32'd0);
    chk("t7_alu_valid", 32'(alu_valid), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("t7_no_dispatch", 32'(alu_valid), 32'd0);
    chk("t7_alu_vj", alu_vj, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
